// File: rtl/multiplier_sequencer.sv
// Sequencer and X:A:B register stage for the 8-bit signed add-shift multiplier.
// Optional macro MULT_SKIP_ZERO_EN: skip the ADD state when the current multiplier bit is 0.
module multiplier_sequencer (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       ClearA_LoadB,
  input  logic [7:0] S,
  input  logic [7:0] add_Sum,
  input  logic       add_X,
  output logic [7:0] add_A,
  output logic [7:0] add_B,
  output logic       add_sub,
  output logic [7:0] Aval,
  output logic [7:0] Bval,
  output logic       Xval,
  output logic       Done
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLR   = 3'd1;
  localparam logic [2:0] ST_ADD   = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0] r_state;
  logic [2:0] r_iter;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic       r_x;
  logic [7:0] r_mcand;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_iter  <= 3'd0;
      r_a     <= 8'd0;
      r_b     <= 8'd0;
      r_x     <= 1'b0;
      r_mcand <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Loading B takes priority; a start waits for the following cycle.
          if (ClearA_LoadB) begin
            r_a <= 8'd0;
            r_x <= 1'b0;
            r_b <= S;
          end else if (Run) begin
            r_state <= ST_CLR;
          end
        end
        ST_CLR: begin
          r_a     <= 8'd0;
          r_x     <= 1'b0;
          r_mcand <= S;
          r_iter  <= 3'd0;
`ifdef MULT_SKIP_ZERO_EN
          r_state <= r_b[0] ? ST_ADD : ST_SHIFT;
`else
          r_state <= ST_ADD;
`endif
        end
        ST_ADD: begin
          if (r_b[0]) begin
            r_a <= add_Sum;
            r_x <= add_X;
          end
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          // Arithmetic right shift of X:A:B; X is the sign and keeps its value.
          r_a <= {r_x, r_a[7:1]};
          r_b <= {r_a[0], r_b[7:1]};
          if (r_iter == 3'd7) begin
            r_state <= ST_DONE;
          end else begin
            r_iter <= r_iter + 3'd1;
`ifdef MULT_SKIP_ZERO_EN
            r_state <= r_b[1] ? ST_ADD : ST_SHIFT;
`else
            r_state <= ST_ADD;
`endif
          end
        end
        ST_DONE: begin
          if (!Run) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The sign bit carries negative weight, so its partial product is subtracted.
  assign add_sub = (r_state == ST_ADD) && (r_iter == 3'd7);
  assign add_A   = r_a;
  assign add_B   = r_mcand;
  assign Aval    = r_a;
  assign Bval    = r_b;
  assign Xval    = r_x;
  assign Done    = (r_state == ST_DONE);

endmodule

// File: tb/tb_multiplier_sequencer.sv
// Scoreboard bench for multiplier_sequencer with a behavioural 9-bit add/subtract adder.
module tb_multiplier_sequencer;

  logic       Clk = 1'b0;
  logic       Reset, Run, ClearA_LoadB;
  logic [7:0] S, add_Sum, add_A, add_B, Aval, Bval;
  logic       add_X, add_sub, Xval, Done;

  multiplier_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .S(S),
    .add_Sum(add_Sum), .add_X(add_X), .add_A(add_A), .add_B(add_B),
    .add_sub(add_sub), .Aval(Aval), .Bval(Bval), .Xval(Xval), .Done(Done)
  );

  always #5 Clk = ~Clk;

  // Sign-extended 9-bit adder; subtract inverts the operand and adds carry-in.
  logic [8:0] w_opa, w_opb, w_sum;
  assign w_opa   = {add_A[7], add_A};
  assign w_opb   = add_sub ? ~{add_B[7], add_B} : {add_B[7], add_B};
  assign w_sum   = w_opa + w_opb + {8'd0, add_sub};
  assign add_Sum = w_sum[7:0];
  assign add_X   = w_sum[8];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       x;
    int         lat;
    int         start;
    string      name;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic prev_done = 1'b0;

  always @(posedge Clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every rising Done must match the oldest queued expectation.
  always @(negedge Clk) begin
    if (!Reset && Done && !prev_done) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got Done=1 expected no product pending");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, "_A"}, {24'd0, Aval}, {24'd0, e.a});
        chk({e.name, "_B"}, {24'd0, Bval}, {24'd0, e.b});
        chk({e.name, "_X"}, {31'd0, Xval}, {31'd0, e.x});
        chk({e.name, "_lat"}, cyc - e.start, e.lat);
      end
    end
    prev_done = Done;
  end

  function automatic int lat_for(input logic [7:0] b);
`ifdef MULT_SKIP_ZERO_EN
    return 9 + $countones(b);
`else
    return 17;
`endif
  endfunction

  task automatic push(input string name, input logic [7:0] b, input logic [7:0] ea,
                      input logic [7:0] eb, input logic ex);
    exp_t e;
    e.a = ea; e.b = eb; e.x = ex; e.lat = lat_for(b); e.start = cyc + 1; e.name = name;
    q.push_back(e);
  endtask

  task automatic load_b(input logic [7:0] b);
    @(negedge Clk);
    ClearA_LoadB = 1'b1;
    S = b;
    @(negedge Clk);
    ClearA_LoadB = 1'b0;
    chk("load_B", {24'd0, Bval}, {24'd0, b});
    chk("load_A", {24'd0, Aval}, 32'd0);
  endtask

  // Waits (bounded) for Done, then optionally holds Run before releasing it.
  task automatic wait_done(input string name, input int hold);
    int n;
    logic [7:0] sa, sb;
    logic sx;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
      if (n == 3) S = 8'hAA;
    end while (!Done && n < 30);
    if (!Done) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got Done=0 expected Done=1 within 30 cycles", name);
      Run = 1'b0;
      return;
    end
    if (hold > 0) begin
      sa = Aval; sb = Bval; sx = Xval;
      repeat (hold) @(negedge Clk);
      chk({name, "_hold_done"}, {31'd0, Done}, 32'd1);
      chk({name, "_hold_regs"}, {15'd0, Xval, Aval, Bval}, {15'd0, sx, sa, sb});
    end
    @(negedge Clk);
    Run = 1'b0;
    @(negedge Clk);
    chk({name, "_done_drop"}, {31'd0, Done}, 32'd0);
  endtask

  task automatic product(input string name, input logic [7:0] b, input logic [7:0] s,
                         input logic [7:0] ea, input logic [7:0] eb, input logic ex,
                         input int hold);
    load_b(b);
    @(negedge Clk);
    S = s;
    Run = 1'b1;
    push(name, b, ea, eb, ex);
    wait_done(name, hold);
  endtask

  initial begin
    Reset = 1'b1; Run = 1'b0; ClearA_LoadB = 1'b0; S = 8'h00;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    chk("reset_regs", {15'd0, Xval, Aval, Bval}, 32'd0);
    chk("reset_done", {31'd0, Done}, 32'd0);

    product("p7xm3",    8'h07, 8'hFD, 8'hFF, 8'hEB, 1'b1, 40);
    product("pm128sq",  8'h80, 8'h80, 8'h40, 8'h00, 1'b0, 0);
    product("pzero",    8'h00, 8'h55, 8'h00, 8'h00, 1'b0, 0);
    product("p5x3",     8'h05, 8'h03, 8'h00, 8'h0F, 1'b0, 0);
    product("pm1x127",  8'hFF, 8'h7F, 8'hFF, 8'h81, 1'b1, 0);
    product("p127xm128",8'h7F, 8'h80, 8'hC0, 8'h80, 1'b1, 0);

    // Load and Run together: load wins, start follows on the next cycle.
    @(negedge Clk);
    ClearA_LoadB = 1'b1; Run = 1'b1; S = 8'h03;
    @(negedge Clk);
    chk("prio_B", {24'd0, Bval}, 32'h03);
    chk("prio_done", {31'd0, Done}, 32'd0);
    ClearA_LoadB = 1'b0; S = 8'hFE;
    push("prio", 8'h03, 8'hFF, 8'hFA, 1'b1);
    wait_done("prio", 0);

    // Reset in the middle of a run.
    load_b(8'h0F);
    @(negedge Clk);
    S = 8'h11; Run = 1'b1;
    repeat (9) @(negedge Clk);
    Reset = 1'b1; Run = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    chk("midreset_regs", {15'd0, Xval, Aval, Bval}, 32'd0);
    chk("midreset_done", {31'd0, Done}, 32'd0);
    repeat (20) @(negedge Clk);
    chk("midreset_idle", {31'd0, Done}, 32'd0);

    product("post_reset", 8'h02, 8'h09, 8'h00, 8'h12, 1'b0, 0);

    repeat (3) @(negedge Clk);
    chk("queue_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
